// File: rtl/mult_copro.sv
// Stack-based 32x32 unsigned multiply co-processor. r15 writes push, r15 reads pop,
// and start multiplies the top two entries, pushing the 64-bit product (low word on top).
module mult_copro #(
  parameter int DEPTH = 8
) (
  input  logic        ck,
  input  logic        rb,
  input  logic        start,
  output logic        ready,
  input  logic        dpsh,
  input  logic [31:0] dinp,
  input  logic        dpop,
  output logic [31:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, MUL, PSH_HI, PSH_LO} state_t;

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [63:0]    acc_reg;
  logic [31:0]    a_reg, b_reg;
  logic [4:0]     step_reg;
  logic [31:0]    mem [DEPTH];

  logic [CW-1:0]  cnt_m1, cnt_m2;
  logic [AW-1:0]  top_idx, nxt_idx, wr_idx;
  logic           wr_en;
  logic [31:0]    wr_data;
  logic [32:0]    sum;
  logic           idle, start_ok;

  assign cnt_m1   = cnt_reg - CW'(1);
  assign cnt_m2   = cnt_reg - CW'(2);
  assign top_idx  = cnt_m1[AW-1:0];
  assign nxt_idx  = cnt_m2[AW-1:0];
  assign idle     = (state_reg == IDLE);
  assign start_ok = idle && start && (cnt_reg >= CW'(2));
  // Combinational so the processor already stalls in the cycle start is accepted.
  assign ready    = idle && !start_ok;
  assign dout     = (cnt_reg != '0) ? mem[top_idx] : 32'd0;
  assign sum      = {1'b0, acc_reg[63:32]} + (b_reg[0] ? {1'b0, a_reg} : 33'd0);

  // Stack pointer and write port; only IDLE honours processor traffic.
  always_comb begin
    cnt_next = cnt_reg;
    wr_en    = 1'b0;
    wr_idx   = cnt_reg[AW-1:0];
    wr_data  = dinp;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          cnt_next = cnt_m2;
        end else if (dpsh && dpop && cnt_reg != '0) begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else if (dpsh && cnt_reg != CW'(DEPTH)) begin
          wr_en    = 1'b1;
          cnt_next = cnt_reg + CW'(1);
        end else if (dpop && !dpsh && cnt_reg != '0) begin
          cnt_next = cnt_m1;
        end
      end
      PSH_HI: begin
        wr_en    = 1'b1;
        wr_data  = acc_reg[63:32];
        cnt_next = cnt_reg + CW'(1);
      end
      PSH_LO: begin
        wr_en    = 1'b1;
        wr_data  = acc_reg[31:0];
        cnt_next = cnt_reg + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge ck or negedge rb) begin
    if (!rb) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      step_reg  <= '0;
    end else begin
      cnt_reg <= cnt_next;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            a_reg     <= mem[top_idx];
            b_reg     <= mem[nxt_idx];
            acc_reg   <= '0;
            step_reg  <= '0;
            state_reg <= MUL;
          end
        end
        MUL: begin
          // Shift-add: the new partial sum enters at the top while the low half shifts right.
          acc_reg  <= {sum, acc_reg[31:1]};
          b_reg    <= b_reg >> 1;
          step_reg <= step_reg + 5'd1;
          if (step_reg == 5'd31) state_reg <= PSH_HI;
        end
        PSH_HI:  state_reg <= PSH_LO;
        PSH_LO:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_copro.md
# mult_copro

Stack-based multiply co-processor attached to the processor's co-processor port. It sits directly downstream of the processor's register-bank and ALU write path. Register writes to r15 push operands onto an internal stack. A start instruction multiplies the top two entries with a sequential unsigned 32x32 shift-add multiplier. The 64-bit product is pushed back onto the stack, and register reads of r15 pop it. While a multiply is in flight, `ready` is low so the program counter stalls.

## Interface
- `DEPTH`, default 8: stack entries; power of two, at least 2.
- `rb`  input  1: asynchronous reset, active low.
- `ck`  input  1: clock, rising edge.
- `start`  input  1: multiply request, decoded from the processor opcode.
- `ready`  output  1: high when idle and able to accept a start.
- `dpsh`  input  1: push `dinp` onto the stack.
- `dinp`  input  32: push data, from the ALU result.
- `dpop`  input  1: pop the top of stack.
- `dout`  output  32: current top of stack, combinational; 0 when empty.

## Operation
- Storage: `DEPTH` x 32 array with a count `cnt` ranging 0..`DEPTH`. Top entry is `mem[cnt-1]`.
- States: IDLE, MUL, PSH_HI, PSH_LO.
- In IDLE only:
  - `dpsh` alone with `cnt<DEPTH`: write `dinp` to `mem[cnt]`, `cnt+1`. Push when full is ignored.
  - `dpop` alone with `cnt>0`: `cnt-1`. Pop when empty is ignored.
  - `dpsh` and `dpop` together with `cnt>0`: overwrite the top with `dinp`; `cnt` unchanged. With `cnt==0`, this acts as a push.
  - `start` with `cnt>=2`:
    - Capture multiplicand `A` = top and multiplier `B` = next.
    - `cnt-2`; clear the 64-bit accumulator and the 5-bit step counter; go to MUL.
    - `dpsh`/`dpop` in the same cycle are ignored.
  - `start` with `cnt<2` is ignored; the state stays IDLE.
- MUL, one step per cycle for 32 cycles:
  - `sum` = {1'b0, `acc[63:32]`} + (`B[0]` ? `A` : 0), 33 bits.
  - `acc` = {`sum`, `acc[31:1]`}; `B` = `B>>1`.
  - After step 31, go to PSH_HI.
- PSH_HI: push `acc[63:32]`, go to PSH_LO.
- PSH_LO: push `acc[31:0]`, go to IDLE.
  - The low word ends on top, so the first pop returns the low word and the second returns the high word.
- Result pushes cannot overflow, because start freed two entries.
- Outside IDLE, `dpsh` and `dpop` are ignored.
- `ready` = (state==IDLE) && !(`start` && `cnt>=2`). It is combinational, so the processor stalls in the start cycle itself.
- `dout` = (`cnt`>0) ? `mem[cnt-1]` : 0, combinational. During MUL, `dout` reflects the reduced `cnt`.
- Arithmetic is unsigned and modulo 2^64; no overflow is possible.

## Timing
- Reset: `rb` low asynchronously forces state to IDLE and clears `cnt`, `acc`, `B`, `A` and the step counter. Array contents need not be cleared.
  - Outputs during and after reset: `ready`=1, `dout`=0.
- Reset asserted mid-multiply aborts the operation. The operands and result are lost and the stack is empty.
- Multiply latency, with `start` sampled high in cycle 0:
  - `ready` is low in cycles 0..34: cycle 0 plus 32 MUL, PSH_HI and PSH_LO cycles.
  - `ready` is high again in cycle 35, with the low word on `dout`.
- Push/pop timing: a push in cycle n is visible on `dout` in cycle n+1. A pop takes effect at the edge ending cycle n.
- A read-modify-write of r15 within one instruction consumes the old top via `dout` in cycle n and replaces it at the same edge.
- Back-to-back start in cycle 35 is accepted if `cnt>=2`.

## Test plan
- Reset and empty stack:
  - Assert `rb`=0 mid-MUL → `ready`=1 and `dout`=0 immediately.
  - `dpop` on empty → `cnt` stays 0.
- Basic multiply:
  - Push 3, push 5, `start` → `ready` low exactly 35 cycles.
  - Then `dout`=15; after `dpop`, `dout`=0 (high word); after a second `dpop`, the stack is empty.
- Full-range multiply: push 0xFFFFFFFF twice, `start` → low word 0x00000001, then high word 0xFFFFFFFE.
- Guards and capacity:
  - `start` with one entry (7) → `ready` stays 1 and `dout` stays 7.
  - Fill 8 entries, then a ninth push → ignored; `dout` = eighth value.
- Simultaneous push/pop: stack holds […,9]; `dpsh`=`dpop`=1 with `dinp`=0x20 → top becomes 0x20, `cnt` unchanged.
- Chained multiply and ignored traffic:
  - Push 2, 3, 4, start (4x3) → stack [2, 0, 12].
  - Pop 12, pop 0, push 12, start → result 24 (low), 0 (high).
  - `dpsh`/`dpop` asserted during MUL are ignored.
